// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment scanner with per-frame data latch and
// blanking gap at each digit switch. Optional decimal points via `SEG_DP_EN.
module seg_scan_driver #(
   parameter int CLK_FREQ       = 50_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter int GAP_CYCLES     = 500,
   parameter int CHAR_MODE      = 1,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] data_in,
`ifdef SEG_DP_EN
   input  logic [5:0]  dp_in,
`endif
   output logic [5:0]  sel,
   output logic [7:0]  seg,
   output logic        frame_start
);

   localparam int DIG_MAX = CLK_FREQ / SCAN_HZ - 1;
   localparam int CW      = (DIG_MAX < 2) ? 1 : $clog2(DIG_MAX + 1);

   localparam logic [CW-1:0] CNT_MAX = CW'(DIG_MAX);
   localparam logic [CW-1:0] GAP     = CW'(GAP_CYCLES);
   localparam logic [5:0]    SEL_OFF = (SEL_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
   localparam logic [7:0]    SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [23:0]   shadow;
   logic          primed;
   logic          wrap;
   logic          dp_on;
   logic [3:0]    nib;
   logic [7:0]    code;
   logic [5:0]    sel_nxt;
   logic [7:0]    seg_nxt;

`ifdef SEG_DP_EN
   logic [5:0] dp_shadow;
`endif

   function automatic logic [6:0] font(input logic [3:0] n);
      logic [6:0] f;
      f = 7'h00;
      if (CHAR_MODE == 0) begin
         case (n)
            4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
            4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
            4'h8: f = 7'h7F;  4'h9: f = 7'h6F;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
            4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  default: f = 7'h71;
         endcase
      end else begin
         case (n)
            4'h0: f = 7'h76;
            4'h1: f = 7'h79;
            4'h2: f = 7'h38;
            4'h3: f = 7'h38;
            4'h4: f = 7'h3F;
            default: f = 7'h00;
         endcase
      end
      return f;
   endfunction

   assign wrap = (cnt == CNT_MAX) && (idx == 3'd0);
   assign nib  = shadow[{idx, 2'b00} +: 4];

`ifdef SEG_DP_EN
   assign dp_on = dp_shadow[idx];
`else
   assign dp_on = 1'b0;
`endif

   // Outputs are computed from the present cnt/idx and registered, giving a
   // one-clock lag. The reset state is not a real slot, so it stays dark.
   always_comb begin
      sel_nxt = SEL_OFF;
      seg_nxt = SEG_OFF;
      code    = 8'h00;
      if (primed && (cnt >= GAP)) begin
         code    = {dp_on, font(nib)};
         sel_nxt = (SEL_ACTIVE_LOW != 0) ? ~(6'b000001 << idx) : (6'b000001 << idx);
         seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~code : code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= CNT_MAX;
         idx         <= 3'd0;
         shadow      <= 24'h0;
         primed      <= 1'b0;
         frame_start <= 1'b0;
         sel         <= SEL_OFF;
         seg         <= SEG_OFF;
      end else begin
         primed      <= 1'b1;
         frame_start <= wrap;
         sel         <= sel_nxt;
         seg         <= seg_nxt;
         if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (idx == 3'd0) begin
               idx    <= 3'd5;
               shadow <= data_in;
            end else begin
               idx <= idx - 3'd1;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef SEG_DP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dp_shadow <= 6'h00;
      else if (wrap)
         dp_shadow <= dp_in;
   end
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: HELLO-font and hex-font instances side by side,
// timeline model feeding an expected queue checked every cycle.
module tb_seg_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [23:0] data_in;
   logic [5:0]  dp_in;
   logic [5:0]  sel_h, sel_x;
   logic [7:0]  seg_h, seg_x;
   logic        fs_h, fs_x;

   typedef struct packed {
      logic       fs;
      logic [5:0] sel;
      logic [7:0] seg_h;
      logic [7:0] seg_x;
   } exp_t;

   exp_t        exp_q[$];
   logic [23:0] lat_d  [8];
   logic [5:0]  lat_dp [8];
   int          k;
   int          n_chk;
   int          n_err;

   seg_scan_driver #(
      .CLK_FREQ(1000), .SCAN_HZ(100), .GAP_CYCLES(2), .CHAR_MODE(1),
      .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
   ) u_hello (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
`ifdef SEG_DP_EN
      .dp_in(dp_in),
`endif
      .sel(sel_h), .seg(seg_h), .frame_start(fs_h)
   );

   seg_scan_driver #(
      .CLK_FREQ(1000), .SCAN_HZ(100), .GAP_CYCLES(2), .CHAR_MODE(0),
      .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
   ) u_hex (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
`ifdef SEG_DP_EN
      .dp_in(dp_in),
`endif
      .sel(sel_x), .seg(seg_x), .frame_start(fs_x)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s k=%0d: got %0h expected %0h", tag, k, got, exp);
      end
   endtask

   function automatic logic [6:0] hello_code(input logic [3:0] n);
      case (n)
         4'h0: return 7'h76;
         4'h1: return 7'h79;
         4'h2: return 7'h38;
         4'h3: return 7'h38;
         4'h4: return 7'h3F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] hex_code(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // Clock kk after release: clock 1 latches frame 0 and shows dark; from
   // clock 2 on, output shows scan position q = kk-2 (10-cycle slots, 2 dark).
   function automatic exp_t model(input int kk);
      exp_t       e;
      int         q, c, ix, f;
      logic [3:0] nib;
      logic       dpb;
      e.fs    = ((kk - 1) % 60 == 0);
      e.sel   = 6'h3F;
      e.seg_h = 8'hFF;
      e.seg_x = 8'hFF;
      if (kk >= 2) begin
         q  = kk - 2;
         c  = q % 10;
         ix = 5 - ((q / 10) % 6);
         f  = (q / 60) % 8;
         if (c >= 2) begin
            nib = lat_d[f][4*ix +: 4];
            dpb = 1'b0;
`ifdef SEG_DP_EN
            dpb = lat_dp[f][ix];
`endif
            e.sel   = ~(6'b000001 << ix);
            e.seg_h = ~{dpb, hello_code(nib)};
            e.seg_x = ~{dpb, hex_code(nib)};
         end
      end
      return e;
   endfunction

   task automatic step();
      exp_t e;
      @(posedge clk);
      k++;
      if ((k - 1) % 60 == 0) begin
         lat_d[((k - 1) / 60) % 8]  = data_in;
         lat_dp[((k - 1) / 60) % 8] = dp_in;
      end
      exp_q.push_back(model(k));
      @(negedge clk);
      e = exp_q.pop_front();
      check("frame_start_h", fs_h, e.fs);
      check("frame_start_x", fs_x, e.fs);
      check("sel_h", sel_h, e.sel);
      check("sel_x", sel_x, e.sel);
      check("seg_hello", seg_h, e.seg_h);
      check("seg_hex", seg_x, e.seg_x);
      check("sel_onehot", ($countones(~sel_h) <= 1), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sel_h"}, sel_h, 6'h3F);
      check({tag, "_sel_x"}, sel_x, 6'h3F);
      check({tag, "_seg_h"}, seg_h, 8'hFF);
      check({tag, "_seg_x"}, seg_x, 8'hFF);
      check({tag, "_fs_h"}, fs_h, 1'b0);
      check({tag, "_fs_x"}, fs_x, 1'b0);
   endtask

   initial begin
      n_chk   = 0;
      n_err   = 0;
      k       = 0;
      rst_n   = 1'b0;
      data_in = 24'h012345;
      dp_in   = 6'b000100;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");

      // Run 1: HELLO frame, mid-frame rotate, hex digits, then a random word.
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (k == 30)  data_in = 24'h501234;
         if (k == 100) data_in = 24'h89ABCD;
         if (k == 160) begin
            data_in = 24'($urandom_range(0, 24'hFFFFFF));
            dp_in   = 6'($urandom_range(0, 63));
         end
      end

      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_end");
      repeat (2) @(negedge clk);

      // Run 2: reset asserted mid-slot (cnt=5, idx=3), then a fresh latch.
      k       = 0;
      data_in = 24'h012345;
      dp_in   = 6'b000100;
      rst_n   = 1'b1;
      for (int i = 0; i < 26; i++) step();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_hold");

      k       = 0;
      data_in = 24'($urandom_range(0, 24'hFFFFFF));
      dp_in   = 6'($urandom_range(0, 63));
      rst_n   = 1'b1;
      for (int i = 0; i < 130; i++) begin
         step();
         if (k == 70) data_in = 24'h4321F0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
